gray_count_decoder: RTL and testbench

//  Receive side of the 4-bit Gray up/down counter: samples a Gray-coded count bus, decodes to binary,

---
 rtl/gdec_pkg.sv | 34 +++
 rtl/gray_count_decoder_if.sv | 29 ++
 rtl/gray_to_bin.sv | 12 +
 rtl/gray_count_decoder.sv | 179 +++++++++++++++++
 tb/tb_gray_count_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gdec_pkg.sv
// Shared types and helpers for the Gray count decoder.
// Holds the FSM state enum, default widths and Gray/popcount helpers.
package gdec_pkg;

    localparam int GDEC_WIDTH       = 4;
    localparam int GDEC_POS_W       = 8;
    localparam int GDEC_ERR_W       = 8;
    localparam int GDEC_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } gdec_state_e;

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_count_decoder_if.sv
// Gray count link: source drives cg, decoder returns status.
// master = count source / consumer logic, slave = decoder.
interface gray_count_decoder_if
    import gdec_pkg::*;
#(
    parameter int WIDTH = GDEC_WIDTH,
    parameter int POS_W = GDEC_POS_W,
    parameter int ERR_W = GDEC_ERR_W
);
    logic [WIDTH-1:0]        cg;
    logic [WIDTH-1:0]        cb;
    logic                    valid;
    logic                    step;
    logic                    dir;
    logic                    wrap;
    logic                    err;
    logic [ERR_W-1:0]        err_cnt;
    logic signed [POS_W-1:0] pos;

    modport master (
        output cg,
        input  cb, valid, step, dir, wrap, err, err_cnt, pos
    );

    modport slave (
        input  cg,
        output cb, valid, step, dir, wrap, err, err_cnt, pos
    );
endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of its Gray bit and all bits above it.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end
endmodule

// File: rtl/gray_count_decoder.sv
// Gray count receiver: decode, step/wrap/error classify, signed position.
// Define GDEC_SYNC_EN to insert a SYNC_STAGES synchronizer ahead of capture.
module gray_count_decoder
    import gdec_pkg::*;
#(
    parameter int WIDTH       = GDEC_WIDTH,
    parameter int POS_W       = GDEC_POS_W,
    parameter int ERR_W       = GDEC_ERR_W,
    parameter int SYNC_STAGES = GDEC_SYNC_STAGES
) (
    input logic                 i_clk,
    input logic                 i_rst,
    gray_count_decoder_if.slave bus
);
    localparam int FILL_W = $clog2(SYNC_STAGES + 2);

    logic [WIDTH-1:0] w_cg_in;

`ifdef GDEC_SYNC_EN
    localparam logic [FILL_W-1:0] FILL = FILL_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.cg;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_cg_in = r_sync[SYNC_STAGES-1];
`else
    localparam logic [FILL_W-1:0] FILL = FILL_W'(1);

    assign w_cg_in = bus.cg;
`endif

    gdec_state_e      r_state, w_state_n;
    logic [FILL_W-1:0] r_fill, w_fill_n;
    logic [WIDTH-1:0] r_cg_q;
    logic [WIDTH-1:0] r_ref_g, w_ref_n;
    logic [WIDTH-1:0] r_cb, w_cb_n;
    logic             r_valid, w_valid_n;
    logic             r_step, w_step_n;
    logic             r_dir, w_dir_n;
    logic             r_wrap, w_wrap_n;
    logic             r_err, w_err_n;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_n;
    logic [POS_W-1:0] r_pos, w_pos_n;

    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_cb_inc;
    int unsigned      w_pc;
    logic             w_zero, w_one, w_multi;
    logic             w_up, w_wrap;
    logic [ERR_W-1:0] w_err_sat;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .i_gray (r_cg_q),
        .o_bin  (w_dec)
    );

    assign w_diff    = r_cg_q ^ r_ref_g;
    assign w_pc      = popcount(32'(w_diff));
    assign w_zero    = (w_pc == 0);
    assign w_one     = (w_pc == 1);
    assign w_multi   = (w_pc > 1);
    assign w_cb_inc  = r_cb + WIDTH'(1);
    assign w_up      = (w_dec == w_cb_inc);
    assign w_wrap    = w_up ? (&r_cb && w_dec == '0)
                            : (r_cb == '0 && &w_dec);
    assign w_err_sat = (&r_err_cnt) ? r_err_cnt : r_err_cnt + ERR_W'(1);

    always_comb begin
        w_state_n   = r_state;
        w_fill_n    = r_fill;
        w_ref_n     = r_ref_g;
        w_cb_n      = r_cb;
        w_valid_n   = r_valid;
        w_step_n    = 1'b0;
        w_dir_n     = r_dir;
        w_wrap_n    = 1'b0;
        w_err_n     = 1'b0;
        w_err_cnt_n = r_err_cnt;
        w_pos_n     = r_pos;
        unique case (r_state)
            // Wait until r_cg_q holds a real sample, not the reset zero.
            S_INIT: begin
                if (r_fill == FILL) begin
                    w_ref_n   = r_cg_q;
                    w_cb_n    = w_dec;
                    w_valid_n = 1'b1;
                    w_state_n = S_TRACK;
                end else begin
                    w_fill_n = r_fill + FILL_W'(1);
                end
            end
            S_TRACK: begin
                if (w_one) begin
                    w_ref_n  = r_cg_q;
                    w_cb_n   = w_dec;
                    w_step_n = 1'b1;
                    w_dir_n  = w_up;
                    w_wrap_n = w_wrap;
                    w_pos_n  = w_up ? r_pos + POS_W'(1)
                                    : r_pos - POS_W'(1);
                end else if (w_multi) begin
                    w_ref_n     = r_cg_q;
                    w_cb_n      = w_dec;
                    w_err_n     = 1'b1;
                    w_err_cnt_n = w_err_sat;
                    w_state_n   = S_FAULT;
                end
            end
            S_FAULT: begin
                if (w_zero) begin
                    w_state_n = S_TRACK;
                end else begin
                    w_ref_n = r_cg_q;
                    w_cb_n  = w_dec;
                    if (w_multi) begin
                        w_err_n     = 1'b1;
                        w_err_cnt_n = w_err_sat;
                    end
                end
            end
            default: begin
                w_state_n = S_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_INIT;
            r_fill    <= '0;
            r_cg_q    <= '0;
            r_ref_g   <= '0;
            r_cb      <= '0;
            r_valid   <= 1'b0;
            r_step    <= 1'b0;
            r_dir     <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_pos     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_fill    <= w_fill_n;
            r_cg_q    <= w_cg_in;
            r_ref_g   <= w_ref_n;
            r_cb      <= w_cb_n;
            r_valid   <= w_valid_n;
            r_step    <= w_step_n;
            r_dir     <= w_dir_n;
            r_wrap    <= w_wrap_n;
            r_err     <= w_err_n;
            r_err_cnt <= w_err_cnt_n;
            r_pos     <= w_pos_n;
        end
    end

    assign bus.cb      = r_cb;
    assign bus.valid   = r_valid;
    assign bus.step    = r_step;
    assign bus.dir     = r_dir;
    assign bus.wrap    = r_wrap;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
    assign bus.pos     = r_pos;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder (WIDTH=4, POS_W=8, ERR_W=8).
// Expected latency follows GDEC_SYNC_EN when the bench is built with it.
module tb_gray_count_decoder;

`ifdef GDEC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    gray_count_decoder_if #(.WIDTH(4), .POS_W(8), .ERR_W(8)) bus ();

    gray_count_decoder #(
        .WIDTH(4), .POS_W(8), .ERR_W(8), .SYNC_STAGES(2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst    = 1'b1;
        bus.cg = g;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        int nstep;
        int nerr;
        int n;
        rst    = 1'b1;
        bus.cg = 4'b0110;
        repeat (3) tick();
        checks++;
        if (bus.cb !== 4'd0) begin
            errors++; $display("FAIL reset_cb: got %0d want 0", bus.cb);
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.valid);
        end
        checks++;
        if (bus.pos !== 8'sd0) begin
            errors++; $display("FAIL reset_pos: got %0d want 0", bus.pos);
        end
        checks++;
        if (bus.err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_errcnt: got %0d want 0", bus.err_cnt);
        end
        rst   = 1'b0;
        nstep = 0;
        nerr  = 0;
        n     = 0;
        while (bus.valid !== 1'b1 && n < 10) begin
            tick();
            n++;
            if (bus.step === 1'b1) nstep++;
            if (bus.err === 1'b1) nerr++;
        end
        repeat (4) begin
            tick();
            if (bus.step === 1'b1) nstep++;
            if (bus.err === 1'b1) nerr++;
        end
        checks++;
        if (bus.valid !== 1'b1) begin
            errors++; $display("FAIL init_valid: got %b want 1", bus.valid);
        end
        checks++;
        if (bus.cb !== 4'd4) begin
            errors++; $display("FAIL init_cb: got %0d want 4", bus.cb);
        end
        checks++;
        if (nstep != 0 || nerr != 0) begin
            errors++;
            $display("FAIL init_quiet: step=%0d err=%0d want 0/0", nstep, nerr);
        end
    endtask

    task automatic test_up_run();
        logic [3:0] gseq [4];
        logic [3:0] bexp [4];
        int nstep;
        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        bexp = '{4'd0, 4'd1, 4'd2, 4'd3};
        do_reset(4'b0000);
        nstep = 0;
        for (int i = 0; i < 4; i++) begin
            bus.cg = gseq[i];
            repeat (4) begin
                tick();
                if (bus.step === 1'b1) nstep++;
            end
            checks++;
            if (bus.cb !== bexp[i]) begin
                errors++;
                $display("FAIL up_cb[%0d]: got %0d want %0d", i, bus.cb, bexp[i]);
            end
        end
        checks++;
        if (nstep != 3) begin
            errors++; $display("FAIL up_steps: got %0d want 3", nstep);
        end
        checks++;
        if (bus.dir !== 1'b1) begin
            errors++; $display("FAIL up_dir: got %b want 1", bus.dir);
        end
        checks++;
        if (bus.pos !== 8'sd3) begin
            errors++; $display("FAIL up_pos: got %0d want 3", bus.pos);
        end
    endtask

    task automatic test_wrap();
        do_reset(4'b1000);
        checks++;
        if (bus.cb !== 4'd15) begin
            errors++; $display("FAIL wrap_start_cb: got %0d want 15", bus.cb);
        end
        bus.cg = 4'b0000;
        repeat (LAT) tick();
        checks++;
        if ({bus.cb, bus.step, bus.dir, bus.wrap} !== {4'd0, 3'b111}) begin
            errors++;
            $display("FAIL wrap_up: cb=%0d step=%b dir=%b wrap=%b want 0/1/1/1",
                     bus.cb, bus.step, bus.dir, bus.wrap);
        end
        checks++;
        if (bus.pos !== 8'sd1) begin
            errors++; $display("FAIL wrap_up_pos: got %0d want 1", bus.pos);
        end
        tick();
        checks++;
        if (bus.wrap !== 1'b0 || bus.step !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: wrap=%b step=%b want 0/0", bus.wrap, bus.step);
        end
        repeat (2) tick();
        bus.cg = 4'b1000;
        repeat (LAT) tick();
        checks++;
        if ({bus.cb, bus.step, bus.dir, bus.wrap} !== {4'd15, 3'b101}) begin
            errors++;
            $display("FAIL wrap_down: cb=%0d step=%b dir=%b wrap=%b want 15/1/0/1",
                     bus.cb, bus.step, bus.dir, bus.wrap);
        end
        checks++;
        if (bus.pos !== 8'sd0) begin
            errors++; $display("FAIL wrap_down_pos: got %0d want 0", bus.pos);
        end
    endtask

    task automatic test_illegal();
        do_reset(4'b0000);
        bus.cg = 4'b0011;
        repeat (LAT) tick();
        checks++;
        if ({bus.err, bus.step, bus.cb} !== {2'b10, 4'd2}) begin
            errors++;
            $display("FAIL illegal: err=%b step=%b cb=%0d want 1/0/2",
                     bus.err, bus.step, bus.cb);
        end
        checks++;
        if (bus.err_cnt !== 8'd1 || bus.pos !== 8'sd0) begin
            errors++;
            $display("FAIL illegal_cnt: errcnt=%0d pos=%0d want 1/0",
                     bus.err_cnt, bus.pos);
        end
        tick();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse: err=%b want 0", bus.err);
        end
        bus.cg = 4'b0010;
        repeat (LAT) tick();
        checks++;
        if ({bus.step, bus.dir, bus.cb} !== {2'b11, 4'd3}) begin
            errors++;
            $display("FAIL recover: step=%b dir=%b cb=%0d want 1/1/3",
                     bus.step, bus.dir, bus.cb);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] gseq [16];
        int nstep;
        int nwrap;
        int nerr;
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        do_reset(4'b0000);
        nstep = 0;
        nwrap = 0;
        for (int i = 0; i < 16 + LAT + 1; i++) begin
            if (i < 16) bus.cg = gseq[i];
            tick();
            if (bus.step === 1'b1) nstep++;
            if (bus.wrap === 1'b1) nwrap++;
        end
        checks++;
        if (nstep != 16 || nwrap != 1) begin
            errors++;
            $display("FAIL b2b_counts: step=%0d wrap=%0d want 16/1", nstep, nwrap);
        end
        checks++;
        if (bus.pos !== 8'sd16 || bus.cb !== 4'd0) begin
            errors++;
            $display("FAIL b2b_state: pos=%0d cb=%0d want 16/0", bus.pos, bus.cb);
        end
        nerr  = 0;
        nstep = 0;
        for (int i = 0; i < 254; i++) begin
            bus.cg = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            tick();
            if (bus.err === 1'b1) nerr++;
            if (bus.step === 1'b1) nstep++;
        end
        repeat (LAT) begin
            tick();
            if (bus.err === 1'b1) nerr++;
            if (bus.step === 1'b1) nstep++;
        end
        checks++;
        if (bus.err_cnt !== 8'd254) begin
            errors++; $display("FAIL errcnt_254: got %0d want 254", bus.err_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            bus.cg = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            tick();
            if (bus.err === 1'b1) nerr++;
            if (bus.step === 1'b1) nstep++;
        end
        repeat (LAT) begin
            tick();
            if (bus.err === 1'b1) nerr++;
            if (bus.step === 1'b1) nstep++;
        end
        checks++;
        if (bus.err_cnt !== 8'd255) begin
            errors++; $display("FAIL errcnt_sat: got %0d want 255", bus.err_cnt);
        end
        checks++;
        if (nerr != 260 || nstep != 0) begin
            errors++;
            $display("FAIL err_pulses: err=%0d step=%0d want 260/0", nerr, nstep);
        end
        checks++;
        if (bus.pos !== 8'sd16) begin
            errors++; $display("FAIL err_pos: got %0d want 16", bus.pos);
        end
    endtask

    task automatic test_mid_reset();
        int nstep;
        int nerr;
        bus.cg = 4'b0011;
        rst    = 1'b1;
        tick();
        checks++;
        if (bus.err_cnt !== 8'd0 || bus.pos !== 8'sd0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst: errcnt=%0d pos=%0d valid=%b want 0/0/0",
                     bus.err_cnt, bus.pos, bus.valid);
        end
        rst   = 1'b0;
        nstep = 0;
        nerr  = 0;
        repeat (8) begin
            tick();
            if (bus.step === 1'b1) nstep++;
            if (bus.err === 1'b1) nerr++;
        end
        checks++;
        if (nstep != 0 || nerr != 0 || bus.cb !== 4'd2 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart: step=%0d err=%0d cb=%0d valid=%b want 0/0/2/1",
                     nstep, nerr, bus.cb, bus.valid);
        end
    endtask

    task automatic test_latency();
        int lat;
        do_reset(4'b0000);
        bus.cg = 4'b0001;
        lat    = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (bus.step === 1'b1) lat = i;
        end
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bus.cb !== 4'd1) begin
            errors++; $display("FAIL latency_cb: got %0d want 1", bus.cb);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.cg = 4'b0000;
        test_reset();
        test_up_run();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
